// File: rtl/output_sram_writer_if.sv
// Output SRAM writer bus.
// Groups the result stream from the compute pipeline with the output SRAM write port.
//   res_valid / res_data / mat_last : result stream, driven by the producer
//   res_ready                       : writer accepts a result this cycle
//   output_sram_write_*             : write strobe, address and data toward the SRAM
// Modports:
//   master : producer / test side
//   slave  : the writer
// Handshake: a result transfers on a rising clk edge where res_valid and res_ready are both 1.
// mat_last is only meaningful while res_valid is 1. The producer may change
// res_data/mat_last freely while res_valid is 0.
interface output_sram_writer_if #(
   parameter int ADDRW = 12,
   parameter int DATAW = 16,
   parameter int RESW  = 20
);
   logic              res_valid;
   logic [RESW-1:0]   res_data;
   logic              mat_last;
   logic              res_ready;
   logic              output_sram_write_enable;
   logic [ADDRW-1:0]  output_sram_write_addresss;
   logic [DATAW-1:0]  output_sram_write_data;

   modport master (
      output res_valid, res_data, mat_last,
      input  res_ready,
      input  output_sram_write_enable, output_sram_write_addresss, output_sram_write_data
   );

   modport slave (
      input  res_valid, res_data, mat_last,
      output res_ready,
      output output_sram_write_enable, output_sram_write_addresss, output_sram_write_data
   );
endinterface

// File: rtl/output_sram_writer.sv
// Output SRAM writer.
// Takes signed max-pool results and saturates each one to int8. It packs two results per
// 16-bit word, with the first result in the low byte. Words are written to consecutive
// SRAM addresses.
// Ports:
//   clk       : clock, rising edge
//   reset_b   : asynchronous reset, active high (1 = in reset)
//   start     : one-cycle pulse, begins a run and clears the address counter
//   finish    : one-cycle pulse, no more results in this run
//   busy      : run in progress (LOW, HIGH, DRAIN)
//   done      : one-cycle pulse after the final write of a run
//   state_dbg : current FSM state encoding
//   bus       : result stream and SRAM write port (slave side)
// An odd-length matrix (mat_last in LOW) is padded with a zero high byte.
module output_sram_writer #(
   parameter int ADDRW = 12,
   parameter int DATAW = 16,
   parameter int RESW  = 20
) (
   input  logic                   clk,
   input  logic                   reset_b,
   input  logic                   start,
   input  logic                   finish,
   output logic                   busy,
   output logic                   done,
   output logic [2:0]             state_dbg,
   output_sram_writer_if.slave    bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOW   = 3'd1,   // no byte held
      HIGH  = 3'd2,   // low byte held in low_q
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic signed [RESW-1:0] SAT_MAX = RESW'(127);
   localparam logic signed [RESW-1:0] SAT_MIN = -RESW'(128);

   state_t             state;
   logic [ADDRW-1:0]   addr_cnt;
   logic [7:0]         low_q;
   logic               we_q;
   logic [ADDRW-1:0]   wr_addr_q;
   logic [DATAW-1:0]   wr_data_q;
   logic               ready_q;
   logic               busy_q;
   logic               done_q;
   logic [7:0]         sat_byte;
   logic               accept;

   always_comb begin
      sat_byte = bus.res_data[7:0];
      if ($signed(bus.res_data) > SAT_MAX) begin
         sat_byte = 8'h7F;
      end else if ($signed(bus.res_data) < SAT_MIN) begin
         sat_byte = 8'h80;
      end
   end

   // res_ready is only ever 1 in LOW/HIGH, so accept never fires elsewhere
   assign accept = bus.res_valid & ready_q;

   always_ff @(posedge clk or posedge reset_b) begin
      if (reset_b) begin
         state     <= IDLE;
         addr_cnt  <= '0;
         low_q     <= '0;
         we_q      <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         // Write strobe and done are single-cycle pulses. Data is zero whenever there is no write.
         we_q      <= 1'b0;
         wr_data_q <= '0;
         done_q    <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= LOW;
                  addr_cnt <= '0;
                  low_q    <= '0;
                  ready_q  <= 1'b1;
                  busy_q   <= 1'b1;
               end
            end
            LOW: begin
               if (accept) begin
                  // finish together with an accept closes the matrix like mat_last
                  if (bus.mat_last || finish) begin
                     we_q      <= 1'b1;
                     wr_data_q <= {8'h00, sat_byte};
                     wr_addr_q <= addr_cnt;
                     addr_cnt  <= addr_cnt + ADDRW'(1);
                  end else begin
                     low_q <= sat_byte;
                     state <= HIGH;
                  end
               end
               if (finish) begin
                  state   <= DRAIN;
                  ready_q <= 1'b0;
               end
            end
            HIGH: begin
               if (accept) begin
                  we_q      <= 1'b1;
                  wr_data_q <= {sat_byte, low_q};
                  wr_addr_q <= addr_cnt;
                  addr_cnt  <= addr_cnt + ADDRW'(1);
                  state     <= LOW;
               end else if (finish) begin
                  // flush the held byte as a padded word
                  we_q      <= 1'b1;
                  wr_data_q <= {8'h00, low_q};
                  wr_addr_q <= addr_cnt;
                  addr_cnt  <= addr_cnt + ADDRW'(1);
               end
               if (finish) begin
                  state   <= DRAIN;
                  ready_q <= 1'b0;
               end
            end
            DRAIN: begin
               // The only write that can be pending is the one strobing this cycle.
               // It completes at this edge, so DRAIN always lasts exactly one cycle.
               state  <= DONE;
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.res_ready                  = ready_q;
   assign bus.output_sram_write_enable   = we_q;
   assign bus.output_sram_write_addresss = wr_addr_q;
   assign bus.output_sram_write_data     = wr_data_q;
   assign busy                           = busy_q;
   assign done                           = done_q;
   assign state_dbg                      = state;

endmodule

// File: tb/tb_output_sram_writer.sv
module tb_output_sram_writer;
   logic       clk;
   logic       reset_b;
   logic       start;
   logic       finish;
   logic       busy;
   logic       done;
   logic [2:0] state_dbg;

   output_sram_writer_if #(.ADDRW(12), .DATAW(16), .RESW(20)) bus ();

   output_sram_writer #(.ADDRW(12), .DATAW(16), .RESW(20)) dut (
      .clk       (clk),
      .reset_b   (reset_b),
      .start     (start),
      .finish    (finish),
      .busy      (busy),
      .done      (done),
      .state_dbg (state_dbg),
      .bus       (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   int          checks = 0;
   int          errors = 0;
   logic [27:0] exp_q[$];        // {addr[11:0], data[15:0]}
   logic [11:0] m_addr;
   bit          m_have_low;
   logic [7:0]  m_low;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] sat8(input logic [19:0] v);
      logic signed [19:0] s;
      s = v;
      if (s > 20'sd127) return 8'h7F;
      if (s < -20'sd128) return 8'h80;
      return v[7:0];
   endfunction

   task automatic push_word(input logic [15:0] d);
      exp_q.push_back({m_addr, d});
      m_addr = m_addr + 12'd1;
   endtask

   task automatic model_res(input logic [19:0] v, input bit last);
      logic [7:0] b;
      b = sat8(v);
      if (!m_have_low) begin
         if (last) push_word({8'h00, b});
         else begin
            m_have_low = 1'b1;
            m_low      = b;
         end
      end else begin
         push_word({b, m_low});
         m_have_low = 1'b0;
      end
   endtask

   // Monitor: every observed write must match the head of the expected queue
   always @(negedge clk) begin
      if (!reset_b) begin
         if (bus.output_sram_write_enable) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_write", {4'h0, bus.output_sram_write_addresss, bus.output_sram_write_data}, 32'hFFFF_FFFF);
            end else begin
               chk("write", {4'h0, bus.output_sram_write_addresss, bus.output_sram_write_data}, {4'h0, exp_q.pop_front()});
            end
         end else begin
            chk("idle_data", {16'h0, bus.output_sram_write_data}, 32'h0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
      m_addr     = 12'd0;
      m_have_low = 1'b0;
   endtask

   task automatic send(input logic [19:0] v, input bit last, input bit mdl);
      bus.res_valid = 1'b1;
      bus.res_data  = v;
      bus.mat_last  = last;
      @(negedge clk);
      chk("res_ready", {31'h0, bus.res_ready}, 32'h1);
      @(posedge clk); #1;
      bus.res_valid = 1'b0;
      bus.mat_last  = 1'b0;
      if (mdl) model_res(v, last);
   endtask

   task automatic do_finish();
      finish = 1'b1;
      @(posedge clk); #1;
      finish = 1'b0;
      if (m_have_low) begin
         push_word({8'h00, m_low});
         m_have_low = 1'b0;
      end
      @(negedge clk);
      chk("ready_after_finish", {31'h0, bus.res_ready}, 32'h0);
      chk("done_drain", {31'h0, done}, 32'h0);
      chk("busy_drain", {31'h0, busy}, 32'h1);
      @(negedge clk);
      chk("done_pulse", {31'h0, done}, 32'h1);
      chk("busy_done", {31'h0, busy}, 32'h0);
      @(negedge clk);
      chk("done_low", {31'h0, done}, 32'h0);
      chk("queue_drained", exp_q.size(), 32'h0);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_we"},    {31'h0, bus.output_sram_write_enable}, 32'h0);
      chk({tag, "_addr"},  {20'h0, bus.output_sram_write_addresss}, 32'h0);
      chk({tag, "_data"},  {16'h0, bus.output_sram_write_data}, 32'h0);
      chk({tag, "_ready"}, {31'h0, bus.res_ready}, 32'h0);
      chk({tag, "_busy"},  {31'h0, busy}, 32'h0);
      chk({tag, "_done"},  {31'h0, done}, 32'h0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset_b       = 1'b1;
      start         = 1'b0;
      finish        = 1'b0;
      bus.res_valid = 1'b0;
      bus.res_data  = '0;
      bus.mat_last  = 1'b0;
      m_addr        = 12'd0;
      m_have_low    = 1'b0;
      m_low         = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk_outputs_zero("reset");
      reset_b = 1'b0;
      @(posedge clk); #1;

      // res_valid and finish in IDLE are ignored
      bus.res_valid = 1'b1;
      bus.res_data  = 20'h00042;
      finish        = 1'b1;
      @(posedge clk); #1;
      bus.res_valid = 1'b0;
      finish        = 1'b0;
      @(negedge clk);
      chk("idle_ignore_busy", {31'h0, busy}, 32'h0);
      chk("idle_ignore_state", {29'h0, state_dbg}, 32'h0);

      // Test 1: 5, -3, 200, -500
      do_start();
      exp_q.push_back({12'd0, 16'hFD05});
      exp_q.push_back({12'd1, 16'h807F});
      send(20'd5, 1'b0, 1'b0);
      send(-20'sd3, 1'b0, 1'b0);
      send(20'd200, 1'b0, 1'b0);
      send(-20'sd500, 1'b1, 1'b0);
      do_finish();

      // Test 2: odd matrix then a second matrix
      do_start();
      exp_q.push_back({12'd0, 16'h0201});
      exp_q.push_back({12'd1, 16'h0003});
      exp_q.push_back({12'd2, 16'h0A09});
      send(20'd1, 1'b0, 1'b0);
      send(20'd2, 1'b0, 1'b0);
      send(20'd3, 1'b1, 1'b0);
      send(20'd9, 1'b0, 1'b0);
      send(20'd10, 1'b1, 1'b0);
      do_finish();

      // Test 3: finish while holding 0x11
      do_start();
      exp_q.push_back({12'd0, 16'h0011});
      send(20'h11, 1'b0, 1'b0);
      m_have_low = 1'b0;
      do_finish();

      // Test 4: continuous valid for 8 cycles, random values across the full range
      do_start();
      for (int i = 0; i < 8; i++) begin
         send(20'($urandom_range(0, 20'hFFFFF)), 1'b0, 1'b1);
      end
      do_finish();

      // Test 5: address counter wrap
      do_start();
      for (int i = 0; i < 8194; i++) begin
         send(20'($urandom_range(0, 20'hFFFFF)), 1'b0, 1'b1);
      end
      do_finish();

      // Test 6: reset mid-pair with a write pending
      do_start();
      send(20'h22, 1'b0, 1'b0);
      bus.res_valid = 1'b1;
      bus.res_data  = 20'h33;
      @(posedge clk); #1;
      bus.res_valid = 1'b0;
      chk("we_pending", {31'h0, bus.output_sram_write_enable}, 32'h1);
      #1 reset_b = 1'b1;
      #1 chk_outputs_zero("mid_reset");
      @(posedge clk); #1;
      reset_b = 1'b0;
      @(posedge clk); #1;
      do_start();
      send(20'h44, 1'b1, 1'b1);
      send(20'h55, 1'b0, 1'b1);
      send(20'h66, 1'b1, 1'b1);
      do_finish();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
